// File: rtl/lbm_pingpong_cache.sv
// lbm_pingpong_cache: double-buffered distribution cache between the AXI-Stream loader/unloader and the LBM solver.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_*                       load stream into the stream-side bank (tvalid/tready/tdata/tlast)
//   m_axis_*                       drain stream out of the stream-side bank (tvalid/tready/tdata/tlast)
//   lbm_addr/we/wdata/rdata        solver port on the solver-owned bank, 1-cycle read latency
//   chunk_ready, chunk_compute_done  solver handshake (bank loaded / solver finished)
//   active_bank, swap_count, load_err  status: solver bank, completed swaps, sticky tlast framing error
module lbm_pingpong_cache #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_DIR       = 9,
  parameter int DEPTH         = 64,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [NUM_DIR*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [NUM_DIR*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  input  logic [ADDRESS_WIDTH-1:0]      lbm_addr,
  input  logic                          lbm_we,
  input  logic [NUM_DIR*DATA_WIDTH-1:0] lbm_wdata,
  output logic [NUM_DIR*DATA_WIDTH-1:0] lbm_rdata,
  output logic                          chunk_ready,
  input  logic                          chunk_compute_done,
  output logic                          active_bank,
  output logic [15:0]                   swap_count,
  output logic                          load_err
);
  localparam int W = NUM_DIR * DATA_WIDTH;
  localparam logic [1:0] ST_LOAD = 2'd0, ST_DRAIN = 2'd1, ST_WAIT = 2'd2;
  localparam logic [ADDRESS_WIDTH:0] LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0] DEP  = (ADDRESS_WIDTH + 1)'(DEPTH);
  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] rd_data_q, buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0] state_q, state_d, cnt_q, cnt_d, dirty_q, dirty_d;
  logic [ADDRESS_WIDTH:0] addr_q, addr_d, out_cnt_q, out_cnt_d;
  logic rd_valid_q, rd_valid_d, chunk_ready_q, chunk_ready_d, done_latched_q, done_latched_d;
  logic active_bank_q, active_bank_d, load_err_q, load_err_d;
  logic [15:0] swap_count_q, swap_count_d;
  logic pop, load_beat, issue, swap, sol_we;
  logic [2:0] occ;
  // Outputs are gated by rst so nothing handshakes during the reset cycle itself.
  assign s_axis_tready = (state_q == ST_LOAD) && !rst;
  assign m_axis_tvalid = (cnt_q != 2'd0) && !rst;
  assign m_axis_tdata  = buf0_q;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == LAST);
  assign chunk_ready   = chunk_ready_q;
  assign active_bank   = active_bank_q;
  assign swap_count    = swap_count_q;
  assign load_err      = load_err_q;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign load_beat = s_axis_tready && s_axis_tvalid;
  assign sol_we    = lbm_we && chunk_ready_q;
  // Buffered words plus the read in flight, net of this cycle's pop, must leave room for one more.
  assign occ   = 3'(cnt_q) + 3'(rd_valid_q) - 3'(pop);
  assign issue = (state_q == ST_DRAIN) && (addr_q < DEP) && (occ < 3'd2);
  assign swap  = (state_q == ST_WAIT) && (!chunk_ready_q || done_latched_q);
  always_comb begin
    state_d        = state_q;
    addr_d         = issue ? addr_q + 1'b1 : addr_q;
    out_cnt_d      = pop ? out_cnt_q + 1'b1 : out_cnt_q;
    rd_valid_d     = issue;
    load_err_d     = load_err_q;
    active_bank_d  = active_bank_q;
    swap_count_d   = swap_count_q;
    dirty_d        = dirty_q;
    chunk_ready_d  = (chunk_compute_done && chunk_ready_q) ? 1'b0 : chunk_ready_q;
    done_latched_d = (chunk_compute_done && chunk_ready_q) ? 1'b1 : done_latched_q;
    if ((state_q == ST_DRAIN) && pop && (out_cnt_q == LAST)) begin
      state_d   = ST_LOAD;
      addr_d    = '0;
      out_cnt_d = '0;
    end
    if (load_beat) begin
      addr_d = addr_q + 1'b1;
      // Early tlast and missing tlast on the final beat both end the chunk and flag a framing error.
      if (s_axis_tlast || (addr_q == LAST)) begin
        state_d    = ST_WAIT;
        load_err_d = load_err_q | (s_axis_tlast != (addr_q == LAST));
      end
    end
    if (swap) begin
      active_bank_d          = !active_bank_q;
      chunk_ready_d          = 1'b1;
      done_latched_d         = 1'b0;
      swap_count_d           = swap_count_q + 16'd1;
      // The released bank holds results only if the solver signalled completion on it.
      dirty_d[active_bank_q] = done_latched_q;
      state_d                = dirty_d[active_bank_q] ? ST_DRAIN : ST_LOAD;
      addr_d                 = '0;
    end
  end
  // Two-entry skid FIFO: head in buf0, a push lands behind whatever survives this cycle's pop.
  always_comb begin
    cnt_d  = cnt_q + 2'(rd_valid_q) - 2'(pop);
    buf0_d = pop ? buf1_q : buf0_q;
    buf1_d = buf1_q;
    if (rd_valid_q && ((cnt_q - 2'(pop)) == 2'd0)) buf0_d = rd_data_q;
    if (rd_valid_q && ((cnt_q - 2'(pop)) == 2'd1)) buf1_d = rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      addr_q         <= '0;
      out_cnt_q      <= '0;
      cnt_q          <= '0;
      rd_valid_q     <= 1'b0;
      chunk_ready_q  <= 1'b0;
      done_latched_q <= 1'b0;
      active_bank_q  <= 1'b0;
      swap_count_q   <= '0;
      load_err_q     <= 1'b0;
      dirty_q        <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      out_cnt_q      <= out_cnt_d;
      cnt_q          <= cnt_d;
      rd_valid_q     <= rd_valid_d;
      chunk_ready_q  <= chunk_ready_d;
      done_latched_q <= done_latched_d;
      active_bank_q  <= active_bank_d;
      swap_count_q   <= swap_count_d;
      load_err_q     <= load_err_d;
      dirty_q        <= dirty_d;
    end
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end
  // Solver and stream always address opposite banks, so each bank sees at most one write per cycle.
  always_ff @(posedge clk) begin
    if (sol_we && !active_bank_q) mem0[lbm_addr] <= lbm_wdata;
    if (sol_we && active_bank_q) mem1[lbm_addr] <= lbm_wdata;
    if (load_beat && active_bank_q) mem0[addr_q[ADDRESS_WIDTH-1:0]] <= s_axis_tdata;
    if (load_beat && !active_bank_q) mem1[addr_q[ADDRESS_WIDTH-1:0]] <= s_axis_tdata;
    lbm_rdata <= active_bank_q ? mem1[lbm_addr] : mem0[lbm_addr];
    rd_data_q <= active_bank_q ? mem0[addr_q[ADDRESS_WIDTH-1:0]] : mem1[addr_q[ADDRESS_WIDTH-1:0]];
  end
endmodule

// File: tb/tb_lbm_pingpong_cache.sv
// tb_lbm_pingpong_cache: directed self-checking bench for lbm_pingpong_cache with DEPTH=4.
module tb_lbm_pingpong_cache;
  localparam int DW = 16, ND = 9, DEPTH = 4, AW = 2, W = DW * ND;
  logic clk = 1'b0, rst = 1'b1;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [W-1:0] s_axis_tdata = '0;
  logic m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [W-1:0] m_axis_tdata;
  logic [AW-1:0] lbm_addr = '0;
  logic lbm_we = 1'b0;
  logic [W-1:0] lbm_wdata = '0, lbm_rdata;
  logic chunk_ready, chunk_compute_done = 1'b0, active_bank, load_err;
  logic [15:0] swap_count;
  int n_checks = 0, n_fail = 0;
  typedef struct { logic [AW-1:0] addr; int exp_beat; } rd_vec_t;
  rd_vec_t rd_tab[4];
  logic [W-1:0] beef, dead;
  always #5 clk = ~clk;
  lbm_pingpong_cache #(.DATA_WIDTH(DW), .NUM_DIR(ND), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .lbm_addr(lbm_addr), .lbm_we(lbm_we), .lbm_wdata(lbm_wdata), .lbm_rdata(lbm_rdata),
    .chunk_ready(chunk_ready), .chunk_compute_done(chunk_compute_done), .active_bank(active_bank),
    .swap_count(swap_count), .load_err(load_err)
  );
  function automatic logic [W-1:0] word(input int b);
    logic [W-1:0] w;
    for (int k = 0; k < ND; k++) w[k*DW +: DW] = 16'(b * 256 + k);
    return w;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic load_chunk(input int base, input int n, input int last_at, input bit done_last);
    for (int i = 0; i < n; i++) begin
      chk1($sformatf("load_tready%0d", i), s_axis_tready, 1'b1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata = word(base + i);
      s_axis_tlast = (i == last_at);
      chunk_compute_done = done_last && (i == n - 1);
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    chunk_compute_done = 1'b0;
  endtask
  task automatic run_reads(input int base);
    for (int i = 0; i < 4; i++) begin
      lbm_addr = rd_tab[i].addr;
      step();
      chkw($sformatf("rd_base%0d_addr%0d", base, rd_tab[i].addr), lbm_rdata, word(base + rd_tab[i].exp_beat));
    end
  endtask
  task automatic drain(input int base, input bit use_beef, input bit toggle, output int cycles);
    int j = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [W-1:0] held = '0;
    while (j < 4 && cyc < 40) begin
      m_axis_tready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (stall) begin
        chk1("stall_valid", m_axis_tvalid, 1'b1);
        chkw("stall_data", m_axis_tdata, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chkw($sformatf("drain_data%0d", j), m_axis_tdata, use_beef ? beef : word(base + j));
        chk1($sformatf("drain_last%0d", j), m_axis_tlast, j == 3);
        j++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      step();
      cyc++;
    end
    chk1("drain_complete", j == 4, 1'b1);
    m_axis_tready = 1'b0;
    cycles = cyc;
  endtask
  initial begin
    int cycles, got;
    rd_tab[0] = '{addr: 2'd2, exp_beat: 2};
    rd_tab[1] = '{addr: 2'd0, exp_beat: 0};
    rd_tab[2] = '{addr: 2'd3, exp_beat: 3};
    rd_tab[3] = '{addr: 2'd1, exp_beat: 1};
    beef = {ND{16'hBEEF}};
    dead = {ND{16'hDEAD}};
    // reset state
    step(); step(); step();
    chk1("rst_tready", s_axis_tready, 1'b0);
    chk1("rst_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_chunk_ready", chunk_ready, 1'b0);
    chk1("rst_active", active_bank, 1'b0);
    chk16("rst_swaps", swap_count, 16'd0);
    chk1("rst_load_err", load_err, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_rst_tready", s_axis_tready, 1'b1);
    // 1: first chunk, immediate swap
    load_chunk(0, 4, 3, 1'b0);
    chk1("t1_wait_tready", s_axis_tready, 1'b0);
    chk1("t1_wait_chunk_ready", chunk_ready, 1'b0);
    step();
    chk1("t1_active", active_bank, 1'b1);
    chk1("t1_chunk_ready", chunk_ready, 1'b1);
    chk16("t1_swaps", swap_count, 16'd1);
    chk1("t1_tready_bank0", s_axis_tready, 1'b1);
    chk1("t1_load_err", load_err, 1'b0);
    run_reads(0);
    // 2: second chunk while solver busy
    load_chunk(4, 4, 3, 1'b0);
    chk1("t2_tready_full", s_axis_tready, 1'b0);
    step(); step();
    chk1("t2_busy_tready", s_axis_tready, 1'b0);
    chk1("t2_busy_active", active_bank, 1'b1);
    chk16("t2_busy_swaps", swap_count, 16'd1);
    // 3: solver writes BEEF, done, swap, drain
    for (int i = 0; i < 4; i++) begin
      lbm_addr = 2'(i);
      lbm_we = 1'b1;
      lbm_wdata = beef;
      step();
      if (i == 0) chkw("t3_rdw_old", lbm_rdata, word(0));
    end
    lbm_we = 1'b0;
    lbm_addr = 2'd0;
    step();
    chkw("t3_wr_readback", lbm_rdata, beef);
    chunk_compute_done = 1'b1;
    step();
    chunk_compute_done = 1'b0;
    chk1("t2_done_chunk_ready", chunk_ready, 1'b0);
    chk1("t2_done_active", active_bank, 1'b1);
    lbm_we = 1'b1;
    lbm_wdata = dead;
    m_axis_tready = 1'b1;
    step();
    lbm_we = 1'b0;
    chk1("t2_swap_active", active_bank, 1'b0);
    chk16("t2_swaps", swap_count, 16'd2);
    chk1("t2_swap_chunk_ready", chunk_ready, 1'b1);
    chk1("t3_tvalid_c0", m_axis_tvalid, 1'b0);
    step();
    chk1("t3_tvalid_c1", m_axis_tvalid, 1'b0);
    step();
    chk1("t3_first_tvalid", m_axis_tvalid, 1'b1);
    drain(0, 1'b1, 1'b0, cycles);
    chk16("t3_drain_rate", 16'(cycles), 16'd4);
    chk1("t3_after_tvalid", m_axis_tvalid, 1'b0);
    chk1("t3_after_tready", s_axis_tready, 1'b1);
    run_reads(4);
    // 4: done coincident with final load beat, stalled drain
    load_chunk(8, 4, 3, 1'b1);
    chk1("t4_chunk_ready_fall", chunk_ready, 1'b0);
    chk1("t4_tready", s_axis_tready, 1'b0);
    step();
    chk1("t4_active", active_bank, 1'b1);
    chk16("t4_swaps", swap_count, 16'd3);
    drain(4, 1'b0, 1'b1, cycles);
    chk1("t4_no_dup", m_axis_tvalid, 1'b0);
    step();
    chk1("t4_no_dup2", m_axis_tvalid, 1'b0);
    chk1("t4_after_tready", s_axis_tready, 1'b1);
    // 5a: early tlast
    load_chunk(12, 2, 1, 1'b0);
    chk1("t5_early_err", load_err, 1'b1);
    chk1("t5_early_tready", s_axis_tready, 1'b0);
    chunk_compute_done = 1'b1;
    step();
    chunk_compute_done = 1'b0;
    chk16("t5_no_swap_yet", swap_count, 16'd3);
    step();
    chk1("t5_swap_active", active_bank, 1'b0);
    chk16("t5_swaps", swap_count, 16'd4);
    // 6: reset mid-drain after beat 1
    m_axis_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (m_axis_tvalid) begin
        chkw($sformatf("t6_beat%0d", got), m_axis_tdata, word(8 + got));
        got++;
      end
      step();
    end
    chk1("t6_two_beats", got == 2, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t6_rst_tvalid_now", m_axis_tvalid, 1'b0);
    chk1("t6_rst_tready_now", s_axis_tready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("t6_tvalid", m_axis_tvalid, 1'b0);
    chk1("t6_chunk_ready", chunk_ready, 1'b0);
    chk16("t6_swaps", swap_count, 16'd0);
    chk1("t6_active", active_bank, 1'b0);
    chk1("t6_tready", s_axis_tready, 1'b1);
    chk1("t6_load_err", load_err, 1'b0);
    step();
    chk1("t6_tvalid_later", m_axis_tvalid, 1'b0);
    m_axis_tready = 1'b0;
    // 5b: missing tlast on the final beat
    load_chunk(0, 4, -1, 1'b0);
    chk1("t5_missing_err", load_err, 1'b1);
    chk1("t5_missing_tready", s_axis_tready, 1'b0);
    step();
    chk1("t5_missing_swap_active", active_bank, 1'b1);
    chk16("t5_missing_swaps", swap_count, 16'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
